// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-master round-robin arbiter and sequencer for the shared synchronous data RAM
//
// Purpose:
//   Serialises accesses from the CPU load/store port (M0) and a loader/DMA
//   engine (M1) onto one synchronous RAM. Each access runs
//   IDLE -> ACCESS -> [WAIT x RD_LAT] -> DONE. Round-robin on ties.
//
// Optional feature macro: DRAM_ARB_LOCK_EN
//   Adds m1_lock_i. M1 may then hold the RAM for up to MAX_LOCK consecutive
//   beats before M0 wins a tie again.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   m0_cs_i/rw_i/addr_i/wdata_i   CPU request (level, held while stalled)
//   m0_rdata_o, m0_stall_o        CPU load data (valid in DONE), pipeline freeze
//   m1_req_i/rw_i/addr_i/wdata_i  M1 request (held until ack)
//   m1_lock_i                     M1 lock request (DRAM_ARB_LOCK_EN only)
//   m1_ack_o, m1_rdata_o          M1 completion pulse and read data
//   ram_cs_o/we_o/addr_o/wdata_o  RAM command (one cs cycle per access)
//   ram_rdata_i                   RAM read data, RD_LAT cycles after cs

module dram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cs_i,
    input  logic              m0_rw_i,
    input  logic [31:0]       m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    output logic [31:0]       m0_rdata_o,
    output logic              m0_stall_o,
    input  logic              m1_req_i,
    input  logic              m1_rw_i,
    input  logic [31:0]       m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
`ifdef DRAM_ARB_LOCK_EN
    input  logic              m1_lock_i,
`endif
    output logic              m1_ack_o,
    output logic [31:0]       m1_rdata_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // WAIT runs RD_LAT cycles; the counter is loaded with RD_LAT-1 (0..3).
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t              state_q;
    logic                owner_q;       // 0 = M0, 1 = M1
    logic                rw_q;          // 1 = read
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [1:0]          cnt_q;
    logic                last_grant_q;
    logic                ram_cs_q;
    logic                ram_we_q;
    logic                m1_ack_q;
    logic [31:0]         m0_rdata_q;
    logic [31:0]         m1_rdata_q;

    logic                any_req;
    logic                grant_m1_d;

    assign any_req = m0_cs_i || m1_req_i;

`ifdef DRAM_ARB_LOCK_EN
    localparam int BW = $clog2(MAX_LOCK + 1);

    logic [BW-1:0] beats_q;
    logic          lock_win;

    // A locked M1 keeps the RAM after its own grant until MAX_LOCK beats.
    assign lock_win   = last_grant_q && m1_req_i && m1_lock_i
                        && (beats_q < BW'(MAX_LOCK));
    assign grant_m1_d = lock_win || (m1_req_i && (!m0_cs_i || !last_grant_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            if (grant_m1_d && m1_lock_i) begin
                // Saturate so a lone locked M1 cannot wrap the counter.
                if (beats_q != BW'(MAX_LOCK)) begin
                    beats_q <= beats_q + 1'b1;
                end
            end else begin
                beats_q <= '0;
            end
        end
    end
`else
    localparam int unused_max_lock = MAX_LOCK;

    // Tie goes to the master that did not win last time.
    assign grant_m1_d = m1_req_i && (!m0_cs_i || !last_grant_q);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            // cs/we/ack are single-cycle pulses, asserted only where set below.
            ram_cs_q <= 1'b0;
            ram_we_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q  <= grant_m1_d;
                        rw_q     <= grant_m1_d ? m1_rw_i : m0_rw_i;
                        addr_q   <= grant_m1_d ? m1_addr_i[ADDR_W+1:2]
                                               : m0_addr_i[ADDR_W+1:2];
                        wdata_q  <= grant_m1_d ? m1_wdata_i : m0_wdata_i;
                        ram_cs_q <= 1'b1;
                        ram_we_q <= grant_m1_d ? !m1_rw_i : !m0_rw_i;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (rw_q) begin
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end else begin
                        m1_ack_q <= owner_q;
                        state_q  <= DONE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        if (owner_q) begin
                            m1_rdata_q <= ram_rdata_i;
                        end else begin
                            m0_rdata_q <= ram_rdata_i;
                        end
                        m1_ack_q <= owner_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                DONE: begin
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_stall_o  = m0_cs_i && !(state_q == DONE && !owner_q);
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign m1_ack_o    = m1_ack_q;
    assign ram_cs_o    = ram_cs_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;

    // Byte-lane and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr_i[1:0], m0_addr_i[31:ADDR_W+2],
                                m1_addr_i[1:0], m1_addr_i[31:ADDR_W+2]};

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter (RD_LAT = 2)

module tb_dram_arbiter;

    localparam int ADDR_W = 14;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              m0_cs_i = 1'b0;
    logic              m0_rw_i = 1'b0;
    logic [31:0]       m0_addr_i = '0;
    logic [31:0]       m0_wdata_i = '0;
    logic [31:0]       m0_rdata_o;
    logic              m0_stall_o;
    logic              m1_req_i = 1'b0;
    logic              m1_rw_i = 1'b0;
    logic [31:0]       m1_addr_i = '0;
    logic [31:0]       m1_wdata_i = '0;
    logic              m1_ack_o;
    logic [31:0]       m1_rdata_o;
    logic              ram_cs_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LOCK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_cs_i    (m0_cs_i),
        .m0_rw_i    (m0_rw_i),
        .m0_addr_i  (m0_addr_i),
        .m0_wdata_i (m0_wdata_i),
        .m0_rdata_o (m0_rdata_o),
        .m0_stall_o (m0_stall_o),
        .m1_req_i   (m1_req_i),
        .m1_rw_i    (m1_rw_i),
        .m1_addr_i  (m1_addr_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_ack_o   (m1_ack_o),
        .m1_rdata_o (m1_rdata_o),
        .ram_cs_o   (ram_cs_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    // Synchronous RAM model with a two-stage read pipeline; junk between reads.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rd_p1 = 32'hBADBAD00;
    logic [31:0] rd_p2 = 32'hBADBAD00;
    always @(posedge clk) begin
        if (ram_cs_o && ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
        if (ram_cs_o && !ram_we_o) rd_p1 <= mem[ram_addr_o];
        else                       rd_p1 <= 32'hBADBAD00;
        rd_p2 <= rd_p1;
    end
    assign ram_rdata_i = rd_p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        vectors++;
        if ({ram_cs_o, ram_we_o, m1_ack_o, m0_stall_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got cs/we/ack/stall=%b want 0000",
                     {ram_cs_o, ram_we_o, m1_ack_o, m0_stall_o});
        end
        vectors++;
        if ({m0_rdata_o, m1_rdata_o} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata got %h/%h want 0/0", m0_rdata_o, m1_rdata_o);
        end
        step();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        vectors++;
        if ({ram_cs_o, m1_ack_o, m0_stall_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset got cs/ack/stall=%b want 000",
                     {ram_cs_o, m1_ack_o, m0_stall_o});
        end
    endtask

    task automatic test_m0_write();
        step();
        m0_cs_i = 1'b1; m0_rw_i = 1'b0;
        m0_addr_i = 32'h0000_0010; m0_wdata_i = 32'hDEADBEEF;
        @(negedge clk);                          // cycle 1: IDLE
        vectors++;
        if ({m0_stall_o, ram_cs_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_c1 got stall/cs=%b want 10", {m0_stall_o, ram_cs_o});
        end
        @(negedge clk);                          // cycle 2: ACCESS
        vectors++;
        if ({ram_cs_o, ram_we_o, m0_stall_o} !== 3'b111 || ram_addr_o !== 14'd4
            || ram_wdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_c2 got cs/we/stall=%b addr=%0d wdata=%h want 111 4 deadbeef",
                     {ram_cs_o, ram_we_o, m0_stall_o}, ram_addr_o, ram_wdata_o);
        end
        @(negedge clk);                          // cycle 3: DONE
        vectors++;
        if ({m0_stall_o, ram_cs_o, m1_ack_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_c3 got stall/cs/ack=%b want 000", {m0_stall_o, ram_cs_o, m1_ack_o});
        end
        step();
        m0_cs_i = 1'b0;
    endtask

    task automatic test_m0_read();
        step();
        m0_cs_i = 1'b1; m0_rw_i = 1'b1; m0_addr_i = 32'h0000_0013;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if (m0_stall_o !== (c != 5) || ram_cs_o !== (c == 2)) begin
                miscompares++;
                $display("FAIL rd_cycle%0d got stall/cs=%b%b want %b%b",
                         c, m0_stall_o, ram_cs_o, c != 5, c == 2);
            end
            if (c == 2) begin
                vectors++;
                if (ram_we_o !== 1'b0 || ram_addr_o !== 14'd4) begin
                    miscompares++;
                    $display("FAIL rd_cmd got we=%b addr=%0d want 0 4", ram_we_o, ram_addr_o);
                end
            end
        end
        vectors++;
        if (m0_rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_data got %h want deadbeef", m0_rdata_o);
        end
        step();
        m0_cs_i = 1'b0;
    endtask

    task automatic test_m1_handshake();
        step();
        m1_req_i = 1'b1; m1_rw_i = 1'b0;
        m1_addr_i = 32'h0000_0022; m1_wdata_i = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);                          // ACCESS
        vectors++;
        if ({ram_cs_o, ram_we_o} !== 2'b11 || ram_addr_o !== 14'd8) begin
            miscompares++;
            $display("FAIL m1_wr_cmd got cs/we=%b addr=%0d want 11 8", {ram_cs_o, ram_we_o}, ram_addr_o);
        end
        @(negedge clk);                          // DONE
        vectors++;
        if (m1_ack_o !== 1'b1) begin
            miscompares++;
            $display("FAIL m1_wr_ack got %b want 1", m1_ack_o);
        end
        step();
        m1_req_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (m1_ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL m1_ack_pulse got %b want 0", m1_ack_o);
        end
        // One-cycle request, then inputs scrambled: access must still complete.
        step();
        m1_req_i = 1'b1; m1_rw_i = 1'b1; m1_addr_i = 32'h0000_0020;
        step();
        m1_req_i = 1'b0; m1_rw_i = 1'b0; m1_addr_i = 32'h0000_0FF0;
        @(negedge clk);                          // ACCESS
        vectors++;
        if ({ram_cs_o, ram_we_o} !== 2'b10 || ram_addr_o !== 14'd8) begin
            miscompares++;
            $display("FAIL m1_rd_latch got cs/we=%b addr=%0d want 10 8", {ram_cs_o, ram_we_o}, ram_addr_o);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);                          // DONE
        vectors++;
        if (m1_ack_o !== 1'b1 || m1_rdata_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL m1_rd_done got ack=%b data=%h want 1 12345678", m1_ack_o, m1_rdata_o);
        end
        vectors++;
        if (m0_rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL m0_rdata_hold got %h want deadbeef", m0_rdata_o);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        int t;
        int p;
        acks = 0;
        step();
        rst = 1'b0;
        m0_cs_i = 1'b1; m0_rw_i = 1'b1; m0_addr_i = 32'h0000_0010;
        m1_req_i = 1'b1; m1_rw_i = 1'b1; m1_addr_i = 32'h0000_0020;
        step();
        rst = 1'b1;
        // 4 read transactions of 5 cycles: M0, M1, M0, M1.
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            t = (c - 1) / 5;
            p = (c - 1) % 5;
            if (m1_ack_o === 1'b1) acks++;
            vectors++;
            if (ram_cs_o !== (p == 1) || m1_ack_o !== (p == 4 && t % 2 == 1)
                || m0_stall_o !== !(p == 4 && t % 2 == 0)) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d got cs/ack/stall=%b%b%b want %b%b%b", c,
                         ram_cs_o, m1_ack_o, m0_stall_o,
                         p == 1, p == 4 && t % 2 == 1, !(p == 4 && t % 2 == 0));
            end
            if (p == 1) begin
                vectors++;
                if (ram_addr_o !== ((t % 2 == 1) ? 14'd8 : 14'd4)) begin
                    miscompares++;
                    $display("FAIL b2b_order%0d got addr=%0d want %0d", t, ram_addr_o,
                             (t % 2 == 1) ? 8 : 4);
                end
            end
        end
        vectors++;
        if (acks != 2) begin
            miscompares++;
            $display("FAIL b2b_ack_count got %0d want 2", acks);
        end
        vectors++;
        if (m0_rdata_o !== 32'hDEADBEEF || m1_rdata_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL b2b_rdata got %h/%h want deadbeef/12345678", m0_rdata_o, m1_rdata_o);
        end
        m0_cs_i = 1'b0;
        m1_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int bad;
        step();
        rst = 1'b0;
        m0_cs_i = 1'b0; m1_req_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        m1_req_i = 1'b1; m1_rw_i = 1'b1; m1_addr_i = 32'h0000_0020;
        step();                                  // ACCESS
        step();                                  // WAIT
        rst = 1'b0;
        m1_req_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_cs_o !== 1'b0 || m1_ack_o !== 1'b0) bad++;
            if (c == 1) begin
                step();
                rst = 1'b1;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_quiet got %0d active cycles want 0", bad);
        end
        vectors++;
        if (m1_rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_rdata got %h want 0", m1_rdata_o);
        end
        step();
        m0_cs_i = 1'b1; m0_rw_i = 1'b0;
        m0_addr_i = 32'h0000_0030; m0_wdata_i = 32'hA5A5_A5A5;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({ram_cs_o, ram_we_o} !== 2'b11 || ram_addr_o !== 14'd12
            || ram_wdata_o !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL post_abort_cmd got cs/we=%b addr=%0d wdata=%h want 11 12 a5a5a5a5",
                     {ram_cs_o, ram_we_o}, ram_addr_o, ram_wdata_o);
        end
        @(negedge clk);
        vectors++;
        if (m0_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_abort_stall got %b want 0", m0_stall_o);
        end
        step();
        m0_cs_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_m0_read();
        test_m1_handshake();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Sequences the single shared data RAM between two requesters.
  - M0: the CPU load/store path, with cs/rw/addr/wdata semantics identical to the EX-stage memory port.
  - M1: a loader/DMA engine using a req/ack handshake.
- Owns the synchronous RAM: registers each access, waits out the read latency, and returns data.
- Stalls the CPU (m0_stall_o) until its access completes.
- Round-robin arbitration guarantees neither master starves.

Parameters:
- ADDR_W, 14: RAM word-address width. RAM index = byte address bits [ADDR_W+1:2].
- RD_LAT, 1: RAM read latency in cycles, range 1..4. ram_rdata_i is valid RD_LAT cycles after the ram_cs_o cycle.
- MAX_LOCK, 4: maximum consecutive M1 beats under lock (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_cs_i  in  1  CPU access request, level.
- m0_rw_i  in  1  1 = read (LW), 0 = write (SW).
- m0_addr_i  in  32  CPU byte address.
- m0_wdata_i  in  32  CPU store data.
- m0_rdata_o  out  32  CPU load data, valid in the DONE cycle.
- m0_stall_o  out  1  freeze PC/pipeline while high.
- m1_req_i  in  1  M1 request, held until ack.
- m1_rw_i  in  1  1 = read, 0 = write.
- m1_addr_i  in  32  M1 byte address.
- m1_wdata_i  in  32  M1 write data.
- m1_ack_o  out  1  one-cycle completion pulse.
- m1_rdata_o  out  32  M1 read data, valid with ack.
- ram_cs_o  out  1  RAM select, one cycle per access.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM word address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - All registered outputs are 0, including ram_cs_o, ram_we_o, m1_ack_o and both rdata outputs.
  - last_grant = 1, so M0 wins the first tie.
  - Reset mid-access aborts the access; no ack is issued and the RAM sees no further cs.
- State IDLE:
  - Sample m0_cs_i and m1_req_i.
  - Only one master requesting: grant it.
  - Both requesting: grant the master other than last_grant.
  - On grant, latch owner, rw, addr[ADDR_W+1:2] and wdata, then go to ACCESS.
  - Neither requesting: stay in IDLE.
- State ACCESS (exactly one cycle):
  - ram_cs_o = 1; ram_we_o = !rw; ram_addr_o and ram_wdata_o driven from the latched values.
  - Write: go to DONE.
  - Read: load cnt = RD_LAT-1 and go to WAIT.
- State WAIT:
  - cnt == 0: capture ram_rdata_i into the owner's rdata register and go to DONE.
  - Otherwise decrement cnt.
  - ram_cs_o = 0.
- State DONE (one cycle):
  - owner = 1: m1_ack_o = 1.
  - Set last_grant = owner and return to IDLE.
  - The rdata register holds its value until that master's next read completes.
- m0_stall_o (combinational) = m0_cs_i && !(state == DONE && owner == 0).
  - The CPU holds its inputs stable while stalled.
  - The CPU advances on the DONE cycle.
- Latency from the request seen in IDLE to completion:
  - Write: 3 cycles (IDLE, ACCESS, DONE).
  - Read: 3 + RD_LAT cycles.
  - Each loss of arbitration adds one full access of the other master.
- m1 protocol:
  - req held high after ack counts as a new request, eligible in the next IDLE.
  - req dropped before ack: the access still completes and ack still pulses.
- Latched request values are immune to input changes after IDLE.
- Low address bits [1:0] are ignored; there is no misalignment error.
- Back-to-back:
  - Both masters continuously requesting alternate M0, M1, M0, ...
  - Each master gets one access per two transactions.

Optional Feature:
- Macro: DRAM_ARB_LOCK_EN.
- Defined:
  - Adds input m1_lock_i (1 bit) and a beat counter, 0..MAX_LOCK.
  - In IDLE, if last_grant = 1, m1_req_i = 1, m1_lock_i = 1 and beats < MAX_LOCK, M1 is granted regardless of m0_cs_i.
  - beats increments per M1 grant.
  - beats clears on any M0 grant or on an M1 grant without lock.
  - After MAX_LOCK locked beats, M0 wins the next tie.
- Undefined: the port is absent and arbitration is pure round-robin as above.

Test Plan:
- Reset then idle → all outputs 0; m0_stall_o = 0 with m0_cs_i = 0.
- M0 write, addr = 0x0000_0010, data = 0xDEADBEEF → ram_cs_o = 1, ram_we_o = 1, ram_addr_o = 4 in cycle 2; stall high for 2 cycles and low on cycle 3.
- M0 read of addr 0x10 with RD_LAT = 2, RAM returning 0xDEADBEEF → m0_rdata_o = 0xDEADBEEF; stall released on cycle 5.
- M0 and M1 both read continuously from reset → grant order M0, M1, M0, M1; m1_ack_o pulses once per M1 access; no two ram_cs_o cycles closer than the access length.
- M1 read in WAIT, rst pulsed low → ram_cs_o stays 0, no ack, state IDLE; next M0 request is served normally.
- With DRAM_ARB_LOCK_EN and MAX_LOCK = 4, M1 locked while M0 requests → 4 consecutive M1 acks, then an M0 grant; without the macro, strict alternation.
